// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - operation codes and widths for the RV32 ALU; ALU_MUL_EN adds MUL/MULHU codes
package alu_pkg;

   localparam int CTR_W = 4;

   typedef logic [CTR_W-1:0] alu_op_t;

   localparam alu_op_t OP_ADD   = 4'b0000;
   localparam alu_op_t OP_SUB   = 4'b1000;
   localparam alu_op_t OP_SLL   = 4'b0001;
   localparam alu_op_t OP_SLT   = 4'b0010;
   localparam alu_op_t OP_SLTU  = 4'b1010;
   localparam alu_op_t OP_COPYB = 4'b0011;
   localparam alu_op_t OP_XOR   = 4'b0100;
   localparam alu_op_t OP_SRL   = 4'b0101;
   localparam alu_op_t OP_SRA   = 4'b1101;
   localparam alu_op_t OP_OR    = 4'b0110;
   localparam alu_op_t OP_AND   = 4'b0111;
`ifdef ALU_MUL_EN
   localparam alu_op_t OP_MUL   = 4'b1001;
   localparam alu_op_t OP_MULHU = 4'b1011;
`endif

endpackage

// File: rtl/alu_addsub.sv
// rtl/alu_addsub.sv - adder/subtractor (a + ~b + 1 when sub) with compare and equality flags
module alu_addsub #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow,
   output logic             signed_less,
   output logic             unsigned_less,
   output logic             eq
);

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum_ext;

   always_comb begin
      b_eff   = b ^ {WIDTH{sub}};
      sum_ext = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
      sum     = sum_ext[WIDTH-1:0];
      carry   = sum_ext[WIDTH];
      // Overflow: operands of equal sign produced a result of the other sign.
      overflow      = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      signed_less   = sum[WIDTH-1] ^ overflow;
      unsigned_less = ~carry;
      eq            = (sum == {WIDTH{1'b0}});
   end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - registered 32-bit RV32 ALU with compare flags; ALU_MUL_EN enables MUL/MULHU
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [CTR_W-1:0] ctr,
   output logic [WIDTH-1:0] out,
   output logic             is_less,
   output logic             is_zero
);

   localparam int SHW = $clog2(WIDTH);

   logic [WIDTH-1:0] diff;
   logic             carry_unused;
   logic             overflow_unused;
   logic             signed_less;
   logic             unsigned_less;
   logic             eq;

   // Always subtracting: the flags must reflect a-b for every ctr, not only SUB.
   alu_addsub #(.WIDTH(WIDTH)) u_addsub (
      .a             (a),
      .b             (b),
      .sub           (1'b1),
      .sum           (diff),
      .carry         (carry_unused),
      .overflow      (overflow_unused),
      .signed_less   (signed_less),
      .unsigned_less (unsigned_less),
      .eq            (eq)
   );

   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] out_d, out_q;
   logic             is_less_d, is_less_q;
   logic             is_zero_d, is_zero_q;

`ifdef ALU_MUL_EN
   logic [2*WIDTH-1:0] prod;
   assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`endif

   assign shamt = b[SHW-1:0];

   always_comb begin
      out_d = '0;
      case (ctr)
         OP_ADD:   out_d = a + b;
         OP_SUB:   out_d = diff;
         OP_SLL:   out_d = a << shamt;
         OP_SLT:   out_d = {{(WIDTH-1){1'b0}}, signed_less};
         OP_SLTU:  out_d = {{(WIDTH-1){1'b0}}, unsigned_less};
         OP_COPYB: out_d = b;
         OP_XOR:   out_d = a ^ b;
         OP_SRL:   out_d = a >> shamt;
         OP_SRA:   out_d = $unsigned($signed(a) >>> shamt);
         OP_OR:    out_d = a | b;
         OP_AND:   out_d = a & b;
`ifdef ALU_MUL_EN
         OP_MUL:   out_d = prod[WIDTH-1:0];
         OP_MULHU: out_d = prod[2*WIDTH-1:WIDTH];
`endif
         default:  out_d = '0;
      endcase
      is_less_d = ctr[CTR_W-1] ? unsigned_less : signed_less;
      is_zero_d = eq;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q     <= '0;
         is_less_q <= 1'b0;
         is_zero_q <= 1'b0;
      end else begin
         out_q     <= out_d;
         is_less_q <= is_less_d;
         is_zero_q <= is_zero_d;
      end
   end

   assign out     = out_q;
   assign is_less = is_less_q;
   assign is_zero = is_zero_q;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - randomized model-checked bench for alu plus literal expectations
`timescale 1ns/1ps
module tb_alu;

   logic        clk;
   logic        rst_n;
   logic [31:0] a;
   logic [31:0] b;
   logic [3:0]  ctr;
   logic [31:0] out;
   logic        is_less;
   logic        is_zero;

   int checks = 0;
   int errors = 0;

   alu dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .a       (a),
      .b       (b),
      .ctr     (ctr),
      .out     (out),
      .is_less (is_less),
      .is_zero (is_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] model_out(input logic [31:0] x, input logic [31:0] y,
                                             input logic [3:0] op);
      int unsigned s;
      longint unsigned p;
      s = y % 32;
      p = longint'(x) * longint'(y);
      case (op)
         4'b0000: return x + y;
         4'b1000: return x - y;
         4'b0001: return x << s;
         4'b0010: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         4'b1010: return (x < y) ? 32'd1 : 32'd0;
         4'b0011: return y;
         4'b0100: return x ^ y;
         4'b0101: return x >> s;
         4'b1101: return x[31] ? ((x >> s) | ~(32'hFFFF_FFFF >> s)) : (x >> s);
         4'b0110: return x | y;
         4'b0111: return x & y;
`ifdef ALU_MUL_EN
         4'b1001: return p[31:0];
         4'b1011: return p[63:32];
`endif
         default: return 32'd0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: expected outputs captured at each edge where the DUT also captures.
   logic [31:0] exp_out;
   logic        exp_less;
   logic        exp_zero;
   logic        exp_valid = 1'b0;

   always @(posedge clk) begin
      if (rst_n) begin
         exp_out   = model_out(a, b, ctr);
         exp_less  = ctr[3] ? (a < b) : ($signed(a) < $signed(b));
         exp_zero  = (a == b);
         exp_valid = 1'b1;
      end
   end

   always @(negedge rst_n) exp_valid = 1'b0;

   always @(negedge clk) begin
      if (rst_n && exp_valid) begin
         chk("model_out", out, exp_out);
         chk("model_is_less", {31'd0, is_less}, {31'd0, exp_less});
         chk("model_is_zero", {31'd0, is_zero}, {31'd0, exp_zero});
      end
   end

   task automatic pin(input string name, input logic [31:0] x, input logic [31:0] y,
                      input logic [3:0] op, input logic [31:0] e_out,
                      input logic e_less, input logic e_zero);
      @(negedge clk);
      a = x; b = y; ctr = op;
      @(posedge clk);
      #1;
      chk({name, "_out"}, out, e_out);
      chk({name, "_less"}, {31'd0, is_less}, {31'd0, e_less});
      chk({name, "_zero"}, {31'd0, is_zero}, {31'd0, e_zero});
   endtask

   initial begin
      rst_n = 1'b0; a = 32'd5; b = 32'd3; ctr = 4'b0000;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out", out, 32'd0);
      chk("rst_less", {31'd0, is_less}, 32'd0);
      chk("rst_zero", {31'd0, is_zero}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("first_out", out, 32'd8);
      chk("first_less", {31'd0, is_less}, 32'd0);
      chk("first_zero", {31'd0, is_zero}, 32'd0);

      pin("add_wrap", 32'hFFFF_FFFF, 32'd1, 4'b0000, 32'h0000_0000, 1'b1, 1'b0);
      pin("sub_eq",   32'd5, 32'd5, 4'b1000, 32'd0, 1'b0, 1'b1);
      pin("sub_wrap", 32'd0, 32'd1, 4'b1000, 32'hFFFF_FFFF, 1'b1, 1'b0);
      pin("slt",      32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd1, 1'b1, 1'b0);
      pin("sltu",     32'hFFFF_FFFF, 32'd1, 4'b1010, 32'd0, 1'b0, 1'b0);
      pin("slt_min",  32'h8000_0000, 32'h8000_0000, 4'b0010, 32'd0, 1'b0, 1'b1);
      pin("sra",      32'h8000_0000, 32'd4, 4'b1101, 32'hF800_0000, 1'b0, 1'b0);
      pin("srl",      32'h8000_0000, 32'd4, 4'b0101, 32'h0800_0000, 1'b1, 1'b0);
      pin("sll_mask", 32'd1, 32'h0000_0023, 4'b0001, 32'h0000_0008, 1'b1, 1'b0);
      pin("sll_zero", 32'h1234_5678, 32'd0, 4'b0001, 32'h1234_5678, 1'b0, 1'b0);
      pin("xor",      32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0100, 32'hFF00_FF00, 1'b1, 1'b0);
      pin("or",       32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0110, 32'hFFF0_FFF0, 1'b1, 1'b0);
      pin("and",      32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0111, 32'h00F0_00F0, 1'b1, 1'b0);
      pin("copyb",    32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0011, 32'h0FF0_0FF0, 1'b1, 1'b0);
      pin("undef",    32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b1111, 32'h0000_0000, 1'b0, 1'b0);
`ifdef ALU_MUL_EN
      pin("mul",      32'hFFFF_FFFF, 32'd2, 4'b1001, 32'hFFFF_FFFE, 1'b0, 1'b0);
      pin("mulhu",    32'hFFFF_FFFF, 32'd2, 4'b1011, 32'h0000_0001, 1'b0, 1'b0);
`else
      pin("mul_off",  32'hFFFF_FFFF, 32'd2, 4'b1001, 32'h0000_0000, 1'b0, 1'b0);
      pin("mulhu_off",32'hFFFF_FFFF, 32'd2, 4'b1011, 32'h0000_0000, 1'b0, 1'b0);
`endif

      // Back-to-back random operations; the compare process checks every edge.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         ctr = 4'($urandom_range(0, 15));
         a   = $urandom;
         case ($urandom_range(0, 5))
            0: b = a;
            1: b = 32'($urandom_range(0, 63));
            2: b = a ^ 32'h8000_0000;
            3: b = {a[31], 31'($urandom)};
            default: b = $urandom;
         endcase
      end

      // Asynchronous reset between edges clears outputs immediately.
      @(negedge clk);
      a = 32'd7; b = 32'd9; ctr = 4'b0000;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out", out, 32'd0);
      chk("midrst_less", {31'd0, is_less}, 32'd0);
      chk("midrst_zero", {31'd0, is_zero}, 32'd0);
      @(posedge clk);
      #1;
      chk("midrst_hold", out, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      pin("after_rst", 32'd10, 32'd3, 4'b1000, 32'd7, 1'b0, 1'b0);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
